// File: rtl/fb_draw_engine.sv
// -----------------------------------------------------------------------------
// fb_draw_engine
//   Command-driven write engine for the framebuffer BRAM write port.
//   A requester issues plot / filled-rectangle / clear commands through a
//   valid/ready handshake. The engine turns each command into a stream of
//   registered (fb_addr, fb_data, fb_we) writes, one pixel per clock, with
//   per-command clipping to the framebuffer bounds.
//
// Ports
//   clk        system clock (the only clock)
//   reset_n    synchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  engine accepts a command this cycle
//   cmd_op     00 plot, 01 rect fill, 10 clear, 11 reserved (no-op)
//   cmd_x0/y0  plot point / rect corner A
//   cmd_x1/y1  rect corner B (ignored for other ops)
//   cmd_color  pixel value written
//   fb_addr    BRAM write address (y*FB_WIDTH + x), registered
//   fb_data    BRAM write data, registered
//   fb_we      BRAM write enable, registered
//   busy       multi-cycle fill in progress
//   done       one-cycle pulse coinciding with the final write of a command
// -----------------------------------------------------------------------------
module fb_draw_engine #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int FB_SIZE   = FB_WIDTH * FB_HEIGHT,
  parameter int FB_ADDRW  = $clog2(FB_SIZE),
  parameter int FB_DATAW  = 1,
  parameter int COORDW    = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [COORDW-1:0]   cmd_x0,
  input  logic [COORDW-1:0]   cmd_y0,
  input  logic [COORDW-1:0]   cmd_x1,
  input  logic [COORDW-1:0]   cmd_y1,
  input  logic [FB_DATAW-1:0] cmd_color,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [FB_DATAW-1:0] fb_data,
  output logic                fb_we,
  output logic                busy,
  output logic                done
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [2:0] OP_PLOT = 3'd0;

  // Coordinates are widened by one bit so that bound compares never wrap.
  localparam logic [COORDW:0]   W_LIM  = (COORDW+1)'(FB_WIDTH);
  localparam logic [COORDW:0]   H_LIM  = (COORDW+1)'(FB_HEIGHT);
  localparam logic [COORDW:0]   X_MAX  = (COORDW+1)'(FB_WIDTH - 1);
  localparam logic [COORDW:0]   Y_MAX  = (COORDW+1)'(FB_HEIGHT - 1);
  localparam logic [FB_ADDRW-1:0] W_ADDR = FB_ADDRW'(FB_WIDTH);

  state_t              state_reg, state_next;
  logic [COORDW:0]     x_reg, x_next;        // column of the pixel on fb_addr
  logic [COORDW:0]     y_reg, y_next;        // row of the pixel on fb_addr
  logic [COORDW:0]     xl_reg, xl_next;      // fill window, inclusive
  logic [COORDW:0]     xh_reg, xh_next;
  logic [COORDW:0]     yh_reg, yh_next;
  logic [FB_ADDRW-1:0] row_base_reg, row_base_next;  // address of (0, y_reg)
  logic [FB_ADDRW-1:0] fb_addr_reg, fb_addr_next;
  logic [FB_DATAW-1:0] fb_data_reg, fb_data_next;
  logic                fb_we_reg, fb_we_next;
  logic                done_reg, done_next;

  // ---- command decode (only meaningful on the accept cycle) ----
  logic [COORDW:0]     x0_w, y0_w, x1_w, y1_w;
  logic [COORDW:0]     rxl, rxh, ryl, ryh, rxh_c, ryh_c;
  logic [COORDW:0]     sxl, sxh, syl, syh;
  logic [COORDW:0]     ax, ay;
  logic                is_clear, rect_hit, plot_hit, accept;
  logic [FB_ADDRW-1:0] acc_row_base;

  assign x0_w = {1'b0, cmd_x0};
  assign y0_w = {1'b0, cmd_y0};
  assign x1_w = {1'b0, cmd_x1};
  assign y1_w = {1'b0, cmd_y1};

  // Normalise corners, then clip the high edge to the framebuffer.
  assign rxl   = (x0_w < x1_w) ? x0_w : x1_w;
  assign rxh   = (x0_w < x1_w) ? x1_w : x0_w;
  assign ryl   = (y0_w < y1_w) ? y0_w : y1_w;
  assign ryh   = (y0_w < y1_w) ? y1_w : y0_w;
  assign rxh_c = (rxh > X_MAX) ? X_MAX : rxh;
  assign ryh_c = (ryh > Y_MAX) ? Y_MAX : ryh;

  assign rect_hit = (rxl < W_LIM) && (ryl < H_LIM);
  assign plot_hit = (x0_w < W_LIM) && (y0_w < H_LIM);
  assign is_clear = (cmd_op == 2'b10);

  // A clear is simply a fill of the whole framebuffer window.
  assign sxl = is_clear ? '0    : rxl;
  assign sxh = is_clear ? X_MAX : rxh_c;
  assign syl = is_clear ? '0    : ryl;
  assign syh = is_clear ? Y_MAX : ryh_c;

  // Starting pixel of the command; the only multiply in the engine.
  assign ax = ({1'b0, cmd_op} == OP_PLOT) ? x0_w : sxl;
  assign ay = ({1'b0, cmd_op} == OP_PLOT) ? y0_w : syl;
  assign acc_row_base = FB_ADDRW'(ay) * W_ADDR;

  assign cmd_ready = reset_n && (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // ---- next-state / output logic ----
  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    xl_next       = xl_reg;
    xh_next       = xh_reg;
    yh_next       = yh_reg;
    row_base_next = row_base_reg;
    fb_addr_next  = fb_addr_reg;
    fb_data_next  = fb_data_reg;
    fb_we_next    = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          fb_data_next = cmd_color;
          fb_addr_next = acc_row_base + FB_ADDRW'(ax);
          done_next    = 1'b1;
          case (cmd_op)
            2'b00: fb_we_next = plot_hit;
            2'b01, 2'b10: begin
              if (is_clear || rect_hit) begin
                state_next    = FILL;
                fb_we_next    = 1'b1;
                x_next        = sxl;
                y_next        = syl;
                xl_next       = sxl;
                xh_next       = sxh;
                yh_next       = syh;
                row_base_next = acc_row_base;
                // A 1x1 window finishes on its first write.
                done_next     = (sxl == sxh) && (syl == syh);
              end
            end
            default: ;  // reserved op: accepted, nothing written
          endcase
        end
      end

      FILL: begin
        // fb_addr currently shows pixel (x_reg, y_reg); advance to the next.
        if ((x_reg == xh_reg) && (y_reg == yh_reg)) begin
          state_next = IDLE;
        end else if (x_reg == xh_reg) begin
          fb_we_next    = 1'b1;
          x_next        = xl_reg;
          y_next        = y_reg + 1'b1;
          row_base_next = row_base_reg + W_ADDR;
          fb_addr_next  = row_base_reg + W_ADDR + FB_ADDRW'(xl_reg);
          done_next     = (xl_reg == xh_reg) && ((y_reg + 1'b1) == yh_reg);
        end else begin
          fb_we_next   = 1'b1;
          x_next       = x_reg + 1'b1;
          fb_addr_next = fb_addr_reg + 1'b1;
          done_next    = ((x_reg + 1'b1) == xh_reg) && (y_reg == yh_reg);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      xl_reg       <= '0;
      xh_reg       <= '0;
      yh_reg       <= '0;
      row_base_reg <= '0;
      fb_addr_reg  <= '0;
      fb_data_reg  <= '0;
      fb_we_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      xl_reg       <= xl_next;
      xh_reg       <= xh_next;
      yh_reg       <= yh_next;
      row_base_reg <= row_base_next;
      fb_addr_reg  <= fb_addr_next;
      fb_data_reg  <= fb_data_next;
      fb_we_reg    <= fb_we_next;
      done_reg     <= done_next;
    end
  end

  assign fb_addr = fb_addr_reg;
  assign fb_data = fb_data_reg;
  assign fb_we   = fb_we_reg;
  assign done    = done_reg;
  assign busy    = (state_reg == FILL);

endmodule

// File: tb/tb_fb_draw_engine.sv
// -----------------------------------------------------------------------------
// tb_fb_draw_engine
//   Two engine instances: a full 640x480x1 one and a small 8x4x4 one (so a
//   clear fits in a short run). A reference model turns each command into the
//   list of expected write addresses by plain loops over the clipped window,
//   and every cycle of the command is compared against it.
// -----------------------------------------------------------------------------
module tb_fb_draw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // shared command bus; sel chooses which instance gets cmd_valid
  logic       sel;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0] cmd_color;
  logic       rst_b_n, rst_s_n;

  logic        b_ready, b_we, b_busy, b_done;
  logic [18:0] b_addr;
  logic [0:0]  b_data;
  logic        s_ready, s_we, s_busy, s_done;
  logic [4:0]  s_addr;
  logic [3:0]  s_data;

  fb_draw_engine #(.FB_WIDTH(640), .FB_HEIGHT(480), .FB_DATAW(1), .COORDW(10)) dut_big (
    .clk(clk), .reset_n(rst_b_n), .cmd_valid(cmd_valid && !sel), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color[0:0]), .fb_addr(b_addr), .fb_data(b_data), .fb_we(b_we),
    .busy(b_busy), .done(b_done));

  fb_draw_engine #(.FB_WIDTH(8), .FB_HEIGHT(4), .FB_DATAW(4), .COORDW(10)) dut_small (
    .clk(clk), .reset_n(rst_s_n), .cmd_valid(cmd_valid && sel), .cmd_ready(s_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .fb_addr(s_addr), .fb_data(s_data), .fb_we(s_we),
    .busy(s_busy), .done(s_done));

  logic        obs_ready, obs_we, obs_busy, obs_done;
  logic [31:0] obs_addr, obs_data;
  always_comb begin
    obs_ready = sel ? s_ready : b_ready;
    obs_we    = sel ? s_we    : b_we;
    obs_busy  = sel ? s_busy  : b_busy;
    obs_done  = sel ? s_done  : b_done;
    obs_addr  = sel ? 32'(s_addr) : 32'(b_addr);
    obs_data  = sel ? 32'(s_data) : 32'(b_data);
  end

  int exp_q[$];
  // command applied right after acceptance while cmd_valid stays high
  logic [1:0] nxt_op;
  logic [9:0] nxt_x0, nxt_y0;
  logic [3:0] nxt_color;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: the set of pixels a command paints, in raster order.
  task automatic model(input int op, input int x0, input int y0, input int x1, input int y1,
                       input int w, input int h, output bit fill);
    int xl, xh, yl, yh;
    exp_q.delete();
    fill = 1'b0;
    case (op)
      0: if (x0 < w && y0 < h) exp_q.push_back(y0 * w + x0);
      1: begin
        xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
        if (xh > w - 1) xh = w - 1;
        if (yh > h - 1) yh = h - 1;
        if (xl < w && yl < h) begin
          fill = 1'b1;
          for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) exp_q.push_back(y * w + x);
        end
      end
      2: begin
        fill = 1'b1;
        for (int a = 0; a < w * h; a++) exp_q.push_back(a);
      end
      default: ;
    endcase
  endtask

  task automatic run_cmd(input string tag, input int op, input int x0, input int y0,
                         input int x1, input int y1, input int color, input bit chain);
    int w, h, d, t, n, edata;
    bit fill;
    w = sel ? 8 : 640;
    h = sel ? 4 : 480;
    edata = sel ? (color & 15) : (color & 1);
    model(op, x0, y0, x1, y1, w, h, fill);
    n = exp_q.size();
    d = (n > 0) ? n : 1;
    cmd_op = 2'(op); cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = 4'(color);
    cmd_valid = 1'b1;
    t = 0;
    while (!obs_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    if (!obs_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (chain) begin
      cmd_op = nxt_op; cmd_x0 = nxt_x0; cmd_y0 = nxt_y0; cmd_color = nxt_color;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int j = 0; j < d; j++) begin
      @(negedge clk);
      check($sformatf("%s_we[%0d]", tag, j), 32'(obs_we), (n > 0) ? 32'd1 : 32'd0);
      if (n > 0) begin
        check($sformatf("%s_addr[%0d]", tag, j), obs_addr, 32'(exp_q[j]));
        check($sformatf("%s_data[%0d]", tag, j), obs_data, 32'(edata));
      end
      check($sformatf("%s_done[%0d]", tag, j), 32'(obs_done), (j == d - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy[%0d]", tag, j), 32'(obs_busy), 32'(fill));
      check($sformatf("%s_rdy[%0d]", tag, j), 32'(obs_ready), 32'(!fill));
    end
    @(negedge clk);
    check({tag, "_end_we"}, 32'(obs_we), 32'd0);
    check({tag, "_end_done"}, 32'(obs_done), 32'd0);
    check({tag, "_end_busy"}, 32'(obs_busy), 32'd0);
    check({tag, "_end_ready"}, 32'(obs_ready), 32'd1);
    $display("cmd %s op=%0d (%0d,%0d)-(%0d,%0d) colour=%0h writes=%0d", tag, op, x0, y0, x1, y1,
             color, n);
  endtask

  // Coordinates biased toward the origin and the far edges.
  function automatic int rnd_coord(input int lim);
    case ($urandom_range(0, 2))
      0: return int'($urandom_range(0, 6));
      1: return lim - 4 + int'($urandom_range(0, 7));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic int near(input int c);
    int v;
    v = c + int'($urandom_range(0, 10)) - 5;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin
    int x0, y0, op;
    bit fill;
    sel = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    nxt_op = '0; nxt_x0 = '0; nxt_y0 = '0; nxt_color = '0;
    rst_b_n = 1'b0; rst_s_n = 1'b0;

    // reset held for 3 clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(b_we), 32'd0);
    check("rst_done", 32'(b_done), 32'd0);
    check("rst_ready", 32'(b_ready), 32'd0);
    check("rst_busy", 32'(b_busy), 32'd0);
    check("rst_addr", 32'(b_addr), 32'd0);
    check("rst_s_we", 32'(s_we), 32'd0);
    rst_b_n = 1'b1; rst_s_n = 1'b1;
    #1;
    check("rel_ready", 32'(b_ready), 32'd1);
    check("rel_s_ready", 32'(s_ready), 32'd1);

    // directed: plots, swapped-corner rect, clipped rect, off-screen rect
    run_cmd("plot_3_2", 0, 3, 2, 0, 0, 1, 1'b0);
    run_cmd("plot_oob", 0, 640, 5, 0, 0, 1, 1'b0);
    run_cmd("rect_swap", 1, 4, 2, 2, 1, 1, 1'b0);
    run_cmd("rect_clip", 1, 638, 478, 700, 900, 1, 1'b0);
    run_cmd("rect_off", 1, 650, 0, 700, 5, 1, 1'b0);
    run_cmd("rect_1x1", 1, 10, 10, 10, 10, 1, 1'b0);
    run_cmd("reserved", 3, 1, 1, 2, 2, 1, 1'b0);

    // small instance: clear with a plot held on cmd_valid throughout
    sel = 1'b1;
    nxt_op = 2'd0; nxt_x0 = 10'd2; nxt_y0 = 10'd1; nxt_color = 4'h5;
    run_cmd("clear_A", 2, 0, 0, 0, 0, 4'hA, 1'b1);
    run_cmd("held_plot", 0, 2, 1, 0, 0, 4'h5, 1'b0);

    // reset in the middle of a clear
    model(2, 0, 0, 0, 0, 8, 4, fill);
    cmd_op = 2'd2; cmd_color = 4'h3; cmd_valid = 1'b1;
    check("abort_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("abort_we[%0d]", j), 32'(s_we), 32'd1);
      check($sformatf("abort_addr[%0d]", j), 32'(s_addr), 32'(exp_q[j]));
    end
    rst_s_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("abort_rst_we", 32'(s_we), 32'd0);
      check("abort_rst_busy", 32'(s_busy), 32'd0);
      check("abort_rst_done", 32'(s_done), 32'd0);
      check("abort_rst_ready", 32'(s_ready), 32'd0);
    end
    rst_s_n = 1'b1;
    #1;
    check("abort_rel_ready", 32'(s_ready), 32'd1);
    $display("cmd abort_clear: reset after 10 writes");
    run_cmd("post_abort", 0, 5, 3, 0, 0, 4'h7, 1'b0);

    // randomized: small instance, all ops including clear
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      x0 = rnd_coord(8); y0 = rnd_coord(4);
      run_cmd($sformatf("rs%0d", i), op, x0, y0, near(x0), near(y0),
              int'($urandom_range(0, 15)), 1'b0);
    end

    // randomized: full-size instance, no clear (too long)
    sel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 2) op = 1;
      x0 = rnd_coord(640); y0 = rnd_coord(480);
      run_cmd($sformatf("rb%0d", i), op, x0, y0, near(x0), near(y0),
              int'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
